// File: rtl/atm_pkg.sv
// Shared types for the ATM transaction engine: op codes, response status codes,
// engine FSM states and the index-width helper.
package atm_pkg;

    typedef enum logic {
        OP_WITHDRAW = 1'b0,
        OP_BALANCE  = 1'b1
    } op_t;

    typedef enum logic [2:0] {
        STAT_OK       = 3'd0,
        STAT_BAD_CARD = 3'd1,
        STAT_BAD_PIN  = 3'd2,
        STAT_LOCKED   = 3'd3,
        STAT_NO_FUNDS = 3'd4,
        STAT_LIMIT    = 3'd5
    } stat_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_CHECK,
        S_RESP
    } state_t;

    // Wide enough for MAX_TRIES up to 7.
    localparam int CNT_W = 3;

    // Index width; a single-entry table still needs a 1-bit index port.
    function automatic int atm_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/atm_txn_engine_if.sv
// Request/response handshake between the card front-end (master) and the
// transaction engine (slave).
interface atm_txn_engine_if #(
    parameter int CARD_W = 10,
    parameter int PIN_W  = 11,
    parameter int BAL_W  = 11
);
    import atm_pkg::*;

    logic              req_valid;
    logic              req_ready;
    op_t               req_op;
    logic [CARD_W-1:0] req_card;
    logic [PIN_W-1:0]  req_pin;
    logic [BAL_W-1:0]  req_amt;
    logic              resp_valid;
    stat_t             resp_stat;
    logic [BAL_W-1:0]  resp_bal;

    modport master (
        output req_valid, req_op, req_card, req_pin, req_amt,
        input  req_ready, resp_valid, resp_stat, resp_bal
    );

    modport slave (
        input  req_valid, req_op, req_card, req_pin, req_amt,
        output req_ready, resp_valid, resp_stat, resp_bal
    );

endinterface

// File: rtl/atm_acct_table.sv
// Account table: card/PIN/balance storage plus valid, fail-count and lock state per entry.
// With ATM_DAILY_LIMIT_EN defined it also keeps a per-entry daily spent counter.
module atm_acct_table
    import atm_pkg::*;
#(
    parameter int  N_USERS = 8,
    parameter int  CARD_W  = 10,
    parameter int  PIN_W   = 11,
    parameter int  BAL_W   = 11,
    localparam int IDX_W   = atm_clog2(N_USERS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_cfg,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [CARD_W-1:0] wr_card,
    input  logic [PIN_W-1:0]  wr_pin,
    input  logic [BAL_W-1:0]  wr_bal,
    input  logic [CNT_W-1:0]  wr_fails,
    input  logic              wr_lock,
`ifdef ATM_DAILY_LIMIT_EN
    input  logic              day_clr,
    input  logic [BAL_W:0]    wr_spent,
    output logic [BAL_W:0]    rd_spent,
`endif
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [CARD_W-1:0] rd_card,
    output logic [PIN_W-1:0]  rd_pin,
    output logic [BAL_W-1:0]  rd_bal,
    output logic [CNT_W-1:0]  rd_fails,
    output logic              rd_lock
);

    logic [CARD_W-1:0]  card_mem [N_USERS];
    logic [PIN_W-1:0]   pin_mem  [N_USERS];
    logic [BAL_W-1:0]   bal_mem  [N_USERS];
    logic [N_USERS-1:0] valid_q;
    logic [N_USERS-1:0] lock_q;
    logic [CNT_W-1:0]   fails_q  [N_USERS];
    logic               wr_ok;

    assign wr_ok = wr_en && (int'(wr_idx) < N_USERS);

    // NOTE: data arrays carry no reset; the valid bits alone decide whether an entry is visible.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            bal_mem[wr_idx] <= wr_bal;
            if (wr_cfg) begin
                card_mem[wr_idx] <= wr_card;
                pin_mem[wr_idx]  <= wr_pin;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            lock_q  <= '0;
            for (int i = 0; i < N_USERS; i++) fails_q[i] <= '0;
        end else if (wr_ok) begin
            if (wr_cfg) begin
                valid_q[wr_idx] <= 1'b1;
                lock_q[wr_idx]  <= 1'b0;
                fails_q[wr_idx] <= '0;
            end else begin
                lock_q[wr_idx]  <= wr_lock;
                fails_q[wr_idx] <= wr_fails;
            end
        end
    end

`ifdef ATM_DAILY_LIMIT_EN
    logic [BAL_W:0] spent_q [N_USERS];

    // day_clr wins over a same-cycle spend update.
    always_ff @(posedge clk) begin
        if (rst || day_clr) begin
            for (int i = 0; i < N_USERS; i++) spent_q[i] <= '0;
        end else if (wr_ok && !wr_cfg) begin
            spent_q[wr_idx] <= wr_spent;
        end
    end

    assign rd_spent = spent_q[rd_idx];
`endif

    assign rd_valid = valid_q[rd_idx];
    assign rd_card  = card_mem[rd_idx];
    assign rd_pin   = pin_mem[rd_idx];
    assign rd_bal   = bal_mem[rd_idx];
    assign rd_fails = fails_q[rd_idx];
    assign rd_lock  = lock_q[rd_idx];

endmodule

// File: rtl/atm_txn_engine.sv
// ATM transaction engine: scans the account table, authenticates, and serves WITHDRAW/BALANCE
// with fixed N_USERS+2 latency. Define ATM_DAILY_LIMIT_EN to build the daily withdraw cap.
module atm_txn_engine
    import atm_pkg::*;
#(
    parameter int  N_USERS   = 8,
    parameter int  CARD_W    = 10,
    parameter int  PIN_W     = 11,
    parameter int  BAL_W     = 11,
    parameter int  MAX_TRIES = 3,
    parameter int  DAY_LIMIT = 500,
    localparam int IDX_W     = atm_clog2(N_USERS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [CARD_W-1:0] cfg_card,
    input  logic [PIN_W-1:0]  cfg_pin,
    input  logic [BAL_W-1:0]  cfg_bal,
    input  logic              day_clr,
    atm_txn_engine_if.slave   txn
);

    state_t            state_q, state_d;
    logic              ready_q, accept, cfg_ok;
    op_t               op_q;
    logic [CARD_W-1:0] card_q;
    logic [PIN_W-1:0]  pin_q;
    logic [BAL_W-1:0]  amt_q;
    logic [IDX_W-1:0]  scan_q, hit_q, rd_idx;
    logic              found_q;
    logic              resp_valid_q;
    stat_t             resp_stat_q;
    logic [BAL_W-1:0]  resp_bal_q;

    logic              rd_valid, rd_lock;
    logic [CARD_W-1:0] rd_card;
    logic [PIN_W-1:0]  rd_pin;
    logic [BAL_W-1:0]  rd_bal;
    logic [CNT_W-1:0]  rd_fails;

    stat_t             chk_stat;
    logic [BAL_W-1:0]  chk_bal, upd_bal;
    logic [CNT_W-1:0]  upd_fails, fails_inc;
    logic              upd_en, upd_lock;

    assign accept = txn.req_valid && ready_q;
    assign cfg_ok = cfg_we && (state_q == S_IDLE);
    assign rd_idx = (state_q == S_SEARCH) ? scan_q : hit_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: assign every always_comb output a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (accept) state_d = S_SEARCH;
            S_SEARCH: if (scan_q == IDX_W'(N_USERS - 1)) state_d = S_CHECK;
            S_CHECK:  state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

`ifdef ATM_DAILY_LIMIT_EN
    logic [BAL_W:0]   rd_spent, upd_spent;
    logic [BAL_W+1:0] spend_sum;
    assign spend_sum = {1'b0, rd_spent} + {2'b00, amt_q};
`else
    logic unused_cfg;
    assign unused_cfg = day_clr ^ (DAY_LIMIT != 0);
`endif

    // Outcome of the CHECK cycle, in priority order.
    always_comb begin
        chk_stat  = STAT_OK;
        chk_bal   = '0;
        upd_en    = 1'b0;
        upd_bal   = rd_bal;
        upd_fails = '0;
        upd_lock  = rd_lock;
        fails_inc = (rd_fails == '1) ? rd_fails : rd_fails + 1'b1;
`ifdef ATM_DAILY_LIMIT_EN
        upd_spent = rd_spent;
`endif
        if (!found_q) begin
            chk_stat = STAT_BAD_CARD;
        end else if (rd_lock) begin
            chk_stat = STAT_LOCKED;
        end else if (rd_pin != pin_q) begin
            chk_stat  = STAT_BAD_PIN;
            upd_en    = 1'b1;
            upd_fails = fails_inc;
            upd_lock  = (fails_inc >= CNT_W'(MAX_TRIES));
        end else begin
            upd_en  = 1'b1;
            chk_bal = rd_bal;
            if (op_q == OP_WITHDRAW) begin
                if (amt_q > rd_bal) begin
                    chk_stat = STAT_NO_FUNDS;
`ifdef ATM_DAILY_LIMIT_EN
                end else if (spend_sum > (BAL_W + 2)'(DAY_LIMIT)) begin
                    chk_stat = STAT_LIMIT;
                    chk_bal  = '0;
`endif
                end else begin
                    chk_bal = rd_bal - amt_q;
                    upd_bal = rd_bal - amt_q;
`ifdef ATM_DAILY_LIMIT_EN
                    upd_spent = spend_sum[BAL_W:0];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_stat_q  <= STAT_OK;
            resp_bal_q   <= '0;
            found_q      <= 1'b0;
            scan_q       <= '0;
            hit_q        <= '0;
            op_q         <= OP_WITHDRAW;
            card_q       <= '0;
            pin_q        <= '0;
            amt_q        <= '0;
        end else begin
            ready_q      <= (state_d == S_IDLE);
            resp_valid_q <= (state_q == S_RESP);
            if (accept) begin
                op_q    <= txn.req_op;
                card_q  <= txn.req_card;
                pin_q   <= txn.req_pin;
                amt_q   <= txn.req_amt;
                scan_q  <= '0;
                found_q <= 1'b0;
            end
            // Full scan every time keeps the latency independent of where the card sits.
            if (state_q == S_SEARCH) begin
                scan_q <= scan_q + 1'b1;
                if (!found_q && rd_valid && rd_card == card_q) begin
                    found_q <= 1'b1;
                    hit_q   <= scan_q;
                end
            end
            if (state_q == S_CHECK) begin
                resp_stat_q <= chk_stat;
                resp_bal_q  <= chk_bal;
            end
        end
    end

    atm_acct_table #(
        .N_USERS (N_USERS),
        .CARD_W  (CARD_W),
        .PIN_W   (PIN_W),
        .BAL_W   (BAL_W)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (cfg_ok || (state_q == S_CHECK && upd_en)),
        .wr_cfg   (cfg_ok),
        .wr_idx   (cfg_ok ? cfg_idx : hit_q),
        .wr_card  (cfg_card),
        .wr_pin   (cfg_pin),
        .wr_bal   (cfg_ok ? cfg_bal : upd_bal),
        .wr_fails (upd_fails),
        .wr_lock  (upd_lock),
`ifdef ATM_DAILY_LIMIT_EN
        .day_clr  (day_clr),
        .wr_spent (upd_spent),
        .rd_spent (rd_spent),
`endif
        .rd_idx   (rd_idx),
        .rd_valid (rd_valid),
        .rd_card  (rd_card),
        .rd_pin   (rd_pin),
        .rd_bal   (rd_bal),
        .rd_fails (rd_fails),
        .rd_lock  (rd_lock)
    );

    assign txn.req_ready  = ready_q;
    assign txn.resp_valid = resp_valid_q;
    assign txn.resp_stat  = resp_stat_q;
    assign txn.resp_bal   = resp_bal_q;

endmodule

// File: tb/tb_atm_txn_engine.sv
// Self-checking bench for atm_txn_engine: vector table for the main ops, hand sequences for
// lockout, cfg timing, reset abort and the daily cap; responses checked through a scoreboard.
module tb_atm_txn_engine;
    import atm_pkg::*;

    localparam int N   = 8;
    localparam int LAT = N + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic [9:0]  cfg_card;
    logic [10:0] cfg_pin;
    logic [10:0] cfg_bal;
    logic        day_clr;

    atm_txn_engine_if #(.CARD_W(10), .PIN_W(11), .BAL_W(11)) bus ();

    atm_txn_engine #(
        .N_USERS(N), .CARD_W(10), .PIN_W(11), .BAL_W(11), .MAX_TRIES(3), .DAY_LIMIT(500)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_idx  (cfg_idx),
        .cfg_card (cfg_card),
        .cfg_pin  (cfg_pin),
        .cfg_bal  (cfg_bal),
        .day_clr  (day_clr),
        .txn      (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        stat_t       st;
        logic [10:0] bal;
        int          acc;
    } exp_t;

    typedef struct {
        op_t         op;
        logic [9:0]  card;
        logic [10:0] pin;
        logic [10:0] amt;
        stat_t       st;
        logic [10:0] bal;
    } vec_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.resp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("resp_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("resp_stat", int'(bus.resp_stat), int'(e.st));
                check("resp_bal", int'(bus.resp_bal), int'(e.bal));
                check("resp_latency", cyc - e.acc, LAT);
            end
        end
    end

    task automatic cfg_write(input logic [2:0] idx, input logic [9:0] card,
                             input logic [10:0] pin, input logic [10:0] bal);
        cfg_idx  = idx;
        cfg_card = card;
        cfg_pin  = pin;
        cfg_bal  = bal;
        cfg_we   = 1'b1;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic issue(input op_t op, input logic [9:0] card, input logic [10:0] pin,
                         input logic [10:0] amt, input stat_t st, input logic [10:0] bal);
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.req_ready !== 1'b1) begin
            check("ready_timeout", 0, 1);
        end else begin
            bus.req_op    = op;
            bus.req_card  = card;
            bus.req_pin   = pin;
            bus.req_amt   = amt;
            bus.req_valid = 1'b1;
            @(posedge clk);
            #1;
            sb_q.push_back('{st, bal, cyc});
            bus.req_valid = 1'b0;
            cfg_we        = 1'b0;
            @(negedge clk);
            check("ready_busy", int'(bus.req_ready), 0);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb_q.size() != 0 && n < 4 * LAT) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check("resp_timeout", 0, 1);
            sb_q.delete();
        end
    endtask

    task automatic txn(input op_t op, input logic [9:0] card, input logic [10:0] pin,
                       input logic [10:0] amt, input stat_t st, input logic [10:0] bal);
        issue(op, card, pin, amt, st, bal);
        wait_done();
    endtask

    vec_t vecs[16];

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_card = '0; cfg_pin = '0; cfg_bal = '0;
        day_clr = 1'b0;
        bus.req_valid = 1'b0; bus.req_op = OP_WITHDRAW;
        bus.req_card = '0; bus.req_pin = '0; bus.req_amt = '0;

        repeat (2) @(negedge clk);
        check("rst_ready", int'(bus.req_ready), 0);
        check("rst_resp_valid", int'(bus.resp_valid), 0);
        check("rst_resp_stat", int'(bus.resp_stat), int'(STAT_OK));
        check("rst_resp_bal", int'(bus.resp_bal), 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", int'(bus.req_ready), 1);

        txn(OP_BALANCE, 10'd5, 11'd9, 11'd0, STAT_BAD_CARD, 11'd0);

        cfg_write(3'd0, 10'd5,    11'd9,    11'd100);
        cfg_write(3'd1, 10'd12,   11'd33,   11'd50);
        cfg_write(3'd3, 10'd5,    11'd1,    11'd999);
        cfg_write(3'd7, 10'd1023, 11'd2047, 11'd2047);

        vecs[0]  = '{OP_WITHDRAW, 10'd5,    11'd9,    11'd30,   STAT_OK,       11'd70};
        vecs[1]  = '{OP_BALANCE,  10'd5,    11'd9,    11'd0,    STAT_OK,       11'd70};
        vecs[2]  = '{OP_WITHDRAW, 10'd5,    11'd9,    11'd70,   STAT_OK,       11'd0};
        vecs[3]  = '{OP_WITHDRAW, 10'd5,    11'd9,    11'd1,    STAT_NO_FUNDS, 11'd0};
        vecs[4]  = '{OP_BALANCE,  10'd5,    11'd1,    11'd0,    STAT_BAD_PIN,  11'd0};
        vecs[5]  = '{OP_BALANCE,  10'd5,    11'd9,    11'd0,    STAT_OK,       11'd0};
        vecs[6]  = '{OP_WITHDRAW, 10'd12,   11'd33,   11'd0,    STAT_OK,       11'd50};
        vecs[7]  = '{OP_WITHDRAW, 10'd12,   11'd33,   11'd51,   STAT_NO_FUNDS, 11'd50};
        vecs[8]  = '{OP_BALANCE,  10'd77,   11'd9,    11'd0,    STAT_BAD_CARD, 11'd0};
        vecs[9]  = '{OP_WITHDRAW, 10'd1023, 11'd2047, 11'd2047, STAT_OK,       11'd0};
        vecs[10] = '{OP_BALANCE,  10'd1023, 11'd2047, 11'd0,    STAT_OK,       11'd0};
        vecs[11] = '{OP_WITHDRAW, 10'd12,   11'd34,   11'd10,   STAT_BAD_PIN,  11'd0};
        vecs[12] = '{OP_WITHDRAW, 10'd12,   11'd33,   11'd10,   STAT_OK,       11'd40};
        vecs[13] = '{OP_WITHDRAW, 10'd12,   11'd34,   11'd10,   STAT_BAD_PIN,  11'd0};
        vecs[14] = '{OP_WITHDRAW, 10'd12,   11'd34,   11'd10,   STAT_BAD_PIN,  11'd0};
        vecs[15] = '{OP_BALANCE,  10'd12,   11'd33,   11'd0,    STAT_OK,       11'd40};

        for (int i = 0; i < 16; i++)
            txn(vecs[i].op, vecs[i].card, vecs[i].pin, vecs[i].amt, vecs[i].st, vecs[i].bal);

        // Lockout after three wrong PINs; the right PIN is then refused too.
        repeat (3) txn(OP_BALANCE, 10'd5, 11'd8, 11'd0, STAT_BAD_PIN, 11'd0);
        txn(OP_BALANCE,  10'd5,  11'd9,  11'd0, STAT_LOCKED, 11'd0);
        txn(OP_BALANCE,  10'd5,  11'd8,  11'd0, STAT_LOCKED, 11'd0);
        txn(OP_BALANCE,  10'd12, 11'd33, 11'd0, STAT_OK,     11'd40);
        cfg_write(3'd0, 10'd5, 11'd9, 11'd100);
        txn(OP_WITHDRAW, 10'd5,  11'd9,  11'd20, STAT_OK,    11'd80);

        // A table write while busy is dropped.
        issue(OP_BALANCE, 10'd12, 11'd33, 11'd0, STAT_OK, 11'd40);
        cfg_idx = 3'd1; cfg_card = 10'd12; cfg_pin = 11'd33; cfg_bal = 11'd500; cfg_we = 1'b1;
        repeat (2) @(negedge clk);
        cfg_we = 1'b0;
        wait_done();
        txn(OP_BALANCE, 10'd12, 11'd33, 11'd0, STAT_OK, 11'd40);

        // Write and accept in the same IDLE cycle: the search sees the new entry.
        cfg_idx = 3'd2; cfg_card = 10'd200; cfg_pin = 11'd7; cfg_bal = 11'd60; cfg_we = 1'b1;
        txn(OP_BALANCE, 10'd200, 11'd7, 11'd0, STAT_OK, 11'd60);

        cfg_write(3'd4, 10'd300, 11'd3, 11'd900);
`ifdef ATM_DAILY_LIMIT_EN
        txn(OP_WITHDRAW, 10'd300, 11'd3, 11'd400,  STAT_OK,       11'd500);
        txn(OP_WITHDRAW, 10'd300, 11'd3, 11'd200,  STAT_LIMIT,    11'd0);
        txn(OP_WITHDRAW, 10'd300, 11'd3, 11'd100,  STAT_OK,       11'd400);
        txn(OP_WITHDRAW, 10'd300, 11'd3, 11'd1,    STAT_LIMIT,    11'd0);
        txn(OP_WITHDRAW, 10'd300, 11'd3, 11'd2000, STAT_NO_FUNDS, 11'd400);
        day_clr = 1'b1;
        @(negedge clk);
        day_clr = 1'b0;
        txn(OP_WITHDRAW, 10'd300, 11'd3, 11'd200,  STAT_OK,       11'd200);
`else
        day_clr = 1'b1;
        @(negedge clk);
        day_clr = 1'b0;
        txn(OP_WITHDRAW, 10'd300, 11'd3, 11'd600,  STAT_OK,       11'd300);
`endif

        // Reset during SEARCH aborts the op and clears the table.
        issue(OP_BALANCE, 10'd12, 11'd33, 11'd0, STAT_OK, 11'd40);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midop_rst_ready", int'(bus.req_ready), 0);
        check("midop_rst_bal", int'(bus.resp_bal), 0);
        rst = 1'b0;
        sb_q.delete();
        repeat (LAT + 4) @(negedge clk);
        txn(OP_BALANCE, 10'd12, 11'd33, 11'd0, STAT_BAD_CARD, 11'd0);
        txn(OP_BALANCE, 10'd5,  11'd9,  11'd0, STAT_BAD_CARD, 11'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
